// File: rtl/arp_eth_rx.sv
// Receive-side ARP parser: takes an Ethernet header plus its AXI-stream payload,
// collects the 28-byte ARP body, validates it and presents one parsed frame per
// valid/ready handshake. Short, malformed or bad-flagged frames are dropped.
module arp_eth_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,

    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,

    output logic                  m_frame_valid,
    input  logic                  m_frame_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [15:0]           m_arp_htype,
    output logic [15:0]           m_arp_ptype,
    output logic [7:0]            m_arp_hlen,
    output logic [7:0]            m_arp_plen,
    output logic [15:0]           m_arp_oper,
    output logic [47:0]           m_arp_sha,
    output logic [31:0]           m_arp_spa,
    output logic [47:0]           m_arp_tha,
    output logic [31:0]           m_arp_tpa,

    output logic                  busy,
    output logic                  error_header_early_termination,
    output logic                  error_invalid_header
);

    localparam int ARP_LEN = 28;

    typedef enum logic [0:0] {
        IDLE,
        READ
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [5:0]            byte_ptr;
    logic [5:0]            ptr_inc;
    logic [5:0]            ptr_next;
    logic [7:0]            body [ARP_LEN];

    logic [KEEP_WIDTH-1:0] eff_keep;
    logic [3:0]            keep_cnt;
    logic [6:0]            received;
    logic [5:0]            lane_pos [KEEP_WIDTH];
    logic [KEEP_WIDTH-1:0] lane_wr;

    logic                  hdr_hs;
    logic                  beat_hs;
    logic                  header_ok;

    assign hdr_hs  = s_eth_hdr_valid && s_eth_hdr_ready;
    assign beat_hs = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;

    // Without tkeep every lane counts as valid.
    assign eff_keep = s_eth_payload_axis_tkeep | {KEEP_WIDTH{KEEP_ENABLE == 0}};

    // Byte count of the current beat and running total at tlast.
    always_comb begin
        keep_cnt = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + 4'(eff_keep[i]);
        end
        received = 7'(byte_ptr) + 7'(keep_cnt);
        ptr_inc  = byte_ptr + 6'(KEEP_WIDTH);
        ptr_next = (ptr_inc > 6'(ARP_LEN)) ? 6'(ARP_LEN) : ptr_inc;
    end

    // Per-lane body offset and write enable; padding beyond the ARP body is ignored.
    always_comb begin
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            lane_pos[i] = byte_ptr + 6'(i);
            lane_wr[i]  = (!s_eth_payload_axis_tlast || eff_keep[i]) &&
                          (lane_pos[i] < 6'(ARP_LEN));
        end
    end

    // Bytes 0-5 always arrive before the tlast beat of any frame of 28+ bytes
    // (beats are at most 8 bytes), so the registered body is safe to check at tlast.
    assign header_ok = (body[0] == 8'h00) && (body[1] == 8'h01) &&
                       (body[2] == 8'h08) && (body[3] == 8'h00) &&
                       (body[4] == 8'h06) && (body[5] == 8'h04);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d                   = state_q;
        s_eth_hdr_ready           = 1'b0;
        s_eth_payload_axis_tready = 1'b0;
        busy                      = 1'b0;
        case (state_q)
            IDLE: begin
                s_eth_hdr_ready = rst && (!m_frame_valid || m_frame_ready);
                if (s_eth_hdr_valid && s_eth_hdr_ready) begin
                    state_d = READ;
                end
            end
            READ: begin
                busy                      = 1'b1;
                s_eth_payload_axis_tready = !m_frame_valid;
                if (beat_hs && s_eth_payload_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ARP body capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ARP_LEN; i++) begin
                body[i] <= '0;
            end
        end else if (beat_hs) begin
            for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
                if (lane_wr[i]) begin
                    body[lane_pos[i][4:0]] <= s_eth_payload_axis_tdata[8*i +: 8];
                end
            end
        end
    end

    // Header latch, byte pointer, frame-valid and error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_ptr                       <= '0;
            m_eth_dest_mac                 <= '0;
            m_eth_src_mac                  <= '0;
            m_eth_type                     <= '0;
            m_frame_valid                  <= 1'b0;
            error_header_early_termination <= 1'b0;
            error_invalid_header           <= 1'b0;
        end else begin
            error_header_early_termination <= 1'b0;
            error_invalid_header           <= 1'b0;

            if (m_frame_valid && m_frame_ready) begin
                m_frame_valid <= 1'b0;
            end

            if (hdr_hs) begin
                m_eth_dest_mac <= s_eth_dest_mac;
                m_eth_src_mac  <= s_eth_src_mac;
                m_eth_type     <= s_eth_type;
                byte_ptr       <= '0;
            end

            if (beat_hs) begin
                if (!s_eth_payload_axis_tlast) begin
                    byte_ptr <= ptr_next;
                end else if (received < 7'(ARP_LEN)) begin
                    error_header_early_termination <= 1'b1;
                end else if (s_eth_payload_axis_tuser) begin
                    m_frame_valid <= 1'b0;
                end else if (!header_ok) begin
                    error_invalid_header <= 1'b1;
                end else begin
                    m_frame_valid <= 1'b1;
                end
            end
        end
    end

    assign m_arp_htype = {body[0], body[1]};
    assign m_arp_ptype = {body[2], body[3]};
    assign m_arp_hlen  = body[4];
    assign m_arp_plen  = body[5];
    assign m_arp_oper  = {body[6], body[7]};
    assign m_arp_sha   = {body[8], body[9], body[10], body[11], body[12], body[13]};
    assign m_arp_spa   = {body[14], body[15], body[16], body[17]};
    assign m_arp_tha   = {body[18], body[19], body[20], body[21], body[22], body[23]};
    assign m_arp_tpa   = {body[24], body[25], body[26], body[27]};

endmodule
